// File: rtl/pdp8_trace.sv
// Hardware trace monitor for the pdp8 CPU: counts instruction fetches, samples
// every Nth fetch into a first-word-fall-through FIFO, and reports HALT and a fetch limit.
module pdp8_trace #(
  parameter int DEPTH    = 16,
  parameter int SAMPLE_W = 16,
  parameter int CYC_W    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [3:0]               state,
  input  logic [14:0]              pc,
  input  logic [11:0]              mb,
  input  logic [11:0]              ac,
  input  logic                     l,
  input  logic                     ion,
  input  logic [SAMPLE_W-1:0]      sample_every,
  input  logic [CYC_W-1:0]         max_cycles,
  input  logic                     rd,
  output logic                     rd_valid,
  output logic [41:0]              rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [7:0]               dropped,
  output logic [CYC_W-1:0]         cycle_count,
  output logic                     limit_hit,
  output logic                     halted,
  output logic [14:0]              halt_pc
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [3:0]  ST_F0    = 4'b0000;
  localparam logic [3:0]  ST_HALT  = 4'b1100;

  logic [3:0]          prev_state_q;
  logic [CYC_W-1:0]    cycle_count_q, cycle_count_d;
  logic [SAMPLE_W-1:0] samp_q, samp_d;
  logic                limit_hit_q, limit_hit_d;
  logic                halted_q, halted_d;
  logic [14:0]         halt_pc_q, halt_pc_d;
  logic                overflow_q, overflow_d;
  logic [7:0]          dropped_q, dropped_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]         count_q, count_d;
  logic [41:0]         mem_q [DEPTH];

  logic                fetch, halt_ev, push, pop, wr_en, full, empty;
  logic [CYC_W-1:0]    cyc_inc;
  logic [SAMPLE_W-1:0] samp_inc;
  logic [41:0]         rec;

  always_comb begin
    fetch         = enable && !limit_hit_q && (state == ST_F0) && (prev_state_q != ST_F0);
    halt_ev       = enable && (state == ST_HALT) && !halted_q;
    cyc_inc       = cycle_count_q + 1'b1;
    samp_inc      = samp_q + 1'b1;
    cycle_count_d = cycle_count_q;
    samp_d        = samp_q;
    limit_hit_d   = limit_hit_q;
    halted_d      = halted_q;
    halt_pc_d     = halt_pc_q;
    push          = 1'b0;
    rec           = {1'b0, ion, l, ac, mb, pc};

    if (fetch) begin
      cycle_count_d = cyc_inc;
      // The fetch that reaches the limit is counted but never recorded.
      if ((max_cycles != '0) && (cyc_inc >= max_cycles)) begin
        limit_hit_d = 1'b1;
      end else if ((sample_every <= SAMPLE_W'(1)) || (samp_inc >= sample_every)) begin
        push   = 1'b1;
        samp_d = '0;
      end else begin
        samp_d = samp_inc;
      end
    end

    if (halt_ev) begin
      halted_d  = 1'b1;
      halt_pc_d = pc;
      push      = 1'b1;
      rec[41]   = 1'b1;
    end

    full       = (count_q == FULL_CNT);
    empty      = (count_q == '0);
    pop        = rd && !empty;
    // A pop frees a slot in the same cycle, so a full FIFO can still accept.
    wr_en      = push && (!full || pop);
    wr_ptr_d   = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    overflow_d = overflow_q;
    dropped_d  = dropped_q;
    if (push && !wr_en) begin
      overflow_d = 1'b1;
      if (dropped_q != 8'hFF) dropped_d = dropped_q + 1'b1;
    end

    unique case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      prev_state_q  <= 4'b1111;
      cycle_count_q <= '0;
      samp_q        <= '0;
      limit_hit_q   <= 1'b0;
      halted_q      <= 1'b0;
      halt_pc_q     <= '0;
      overflow_q    <= 1'b0;
      dropped_q     <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      prev_state_q  <= state;
      cycle_count_q <= cycle_count_d;
      samp_q        <= samp_d;
      limit_hit_q   <= limit_hit_d;
      halted_q      <= halted_d;
      halt_pc_q     <= halt_pc_d;
      overflow_q    <= overflow_d;
      dropped_q     <= dropped_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= rec;
  end

  assign rd_valid    = (count_q != '0);
  assign rd_data     = mem_q[rd_ptr_q];
  assign count       = count_q;
  assign overflow    = overflow_q;
  assign dropped     = dropped_q;
  assign cycle_count = cycle_count_q;
  assign limit_hit   = limit_hit_q;
  assign halted      = halted_q;
  assign halt_pc     = halt_pc_q;

endmodule

// File: tb/tb_pdp8_trace.sv
// Directed bench for pdp8_trace using a 4-entry FIFO so overflow is reachable quickly.
module tb_pdp8_trace;

  logic        clk, reset, enable;
  logic [3:0]  state;
  logic [14:0] pc;
  logic [11:0] mb, ac;
  logic        l, ion;
  logic [15:0] sample_every;
  logic [31:0] max_cycles;
  logic        rd;
  logic        rd_valid;
  logic [41:0] rd_data;
  logic [2:0]  count;
  logic        overflow;
  logic [7:0]  dropped;
  logic [31:0] cycle_count;
  logic        limit_hit, halted;
  logic [14:0] halt_pc;

  int checks = 0;
  int errors = 0;

  pdp8_trace #(.DEPTH(4), .SAMPLE_W(16), .CYC_W(32)) dut (
    .clk(clk), .reset(reset), .enable(enable), .state(state), .pc(pc), .mb(mb),
    .ac(ac), .l(l), .ion(ion), .sample_every(sample_every), .max_cycles(max_cycles),
    .rd(rd), .rd_valid(rd_valid), .rd_data(rd_data), .count(count),
    .overflow(overflow), .dropped(dropped), .cycle_count(cycle_count),
    .limit_hit(limit_hit), .halted(halted), .halt_pc(halt_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    state = 4'h1;
    rd    = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic do_fetch(input logic [14:0] p, input logic [11:0] m, input logic [11:0] a,
                          input logic lv, input logic iv);
    pc = p; mb = m; ac = a; l = lv; ion = iv;
    state = 4'h0;
    tick();
    state = 4'h1;
    tick();
  endtask

  task automatic pop();
    rd = 1'b1;
    tick();
    rd = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %0h exp 0", rd_valid); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (cycle_count !== 32'd0) begin errors++; $display("FAIL reset_cycle got %0d exp 0", cycle_count); end
    checks++; if ({overflow, limit_hit, halted} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {overflow, limit_hit, halted}); end
    checks++; if (dropped !== 8'd0) begin errors++; $display("FAIL reset_dropped got %0d exp 0", dropped); end
    checks++; if (halt_pc !== 15'd0) begin errors++; $display("FAIL reset_halt_pc got %o exp 0", halt_pc); end
  endtask

  task automatic test_basic();
    logic [41:0] exp_rec [3];
    sample_every = 16'd0; max_cycles = 32'd0;
    do_reset();
    do_fetch(15'o00200, 12'o7200, 12'o0001, 1'b0, 1'b0);
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL basic_first_valid got %0h exp 1", rd_valid); end
    do_fetch(15'o00201, 12'o1210, 12'o0002, 1'b1, 1'b1);
    do_fetch(15'o00202, 12'o3211, 12'o7777, 1'b0, 1'b1);
    exp_rec[0] = {1'b0, 1'b0, 1'b0, 12'o0001, 12'o7200, 15'o00200};
    exp_rec[1] = {1'b0, 1'b1, 1'b1, 12'o0002, 12'o1210, 15'o00201};
    exp_rec[2] = {1'b0, 1'b1, 1'b0, 12'o7777, 12'o3211, 15'o00202};
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL basic_count got %0d exp 3", count); end
    checks++; if (cycle_count !== 32'd3) begin errors++; $display("FAIL basic_cycle got %0d exp 3", cycle_count); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (rd_data !== exp_rec[i]) begin errors++; $display("FAIL basic_rec%0d got %h exp %h", i, rd_data, exp_rec[i]); end
      pop();
    end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL basic_empty got %0h exp 0", rd_valid); end
  endtask

  task automatic test_decimation();
    sample_every = 16'd3; max_cycles = 32'd0;
    do_reset();
    for (int i = 0; i < 7; i++) do_fetch(15'o00200 + 15'(i), 12'o1000 + 12'(i), 12'd0, 1'b0, 1'b0);
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL dec_count got %0d exp 2", count); end
    checks++; if (cycle_count !== 32'd7) begin errors++; $display("FAIL dec_cycle got %0d exp 7", cycle_count); end
    checks++; if (rd_data[26:0] !== {12'o1002, 15'o00202}) begin errors++; $display("FAIL dec_rec0 got %h exp %h", rd_data[26:0], {12'o1002, 15'o00202}); end
    pop();
    checks++; if (rd_data[26:0] !== {12'o1005, 15'o00205}) begin errors++; $display("FAIL dec_rec1 got %h exp %h", rd_data[26:0], {12'o1005, 15'o00205}); end
    pop();
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL dec_empty got %0h exp 0", rd_valid); end
  endtask

  task automatic test_limit();
    logic exp_lim;
    sample_every = 16'd0; max_cycles = 32'd4;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      do_fetch(15'o00300 + 15'(i), 12'd0, 12'd0, 1'b0, 1'b0);
      exp_lim = (i >= 3);
      checks++; if (limit_hit !== exp_lim) begin errors++; $display("FAIL limit_flag_f%0d got %0h exp %0h", i + 1, limit_hit, exp_lim); end
    end
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL limit_count got %0d exp 3", count); end
    checks++; if (cycle_count !== 32'd4) begin errors++; $display("FAIL limit_cycle got %0d exp 4", cycle_count); end
    max_cycles = 32'd0;
  endtask

  task automatic test_overflow();
    logic [14:0] exp_pc [4];
    sample_every = 16'd0; max_cycles = 32'd0;
    do_reset();
    for (int i = 0; i < 6; i++) do_fetch(15'o00400 + 15'(i), 12'd0, 12'd0, 1'b0, 1'b0);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL ovf_count got %0d exp 4", count); end
    checks++; if (dropped !== 8'd2) begin errors++; $display("FAIL ovf_dropped got %0d exp 2", dropped); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0h exp 1", overflow); end
    checks++; if (rd_data[14:0] !== 15'o00400) begin errors++; $display("FAIL ovf_head got %o exp 400", rd_data[14:0]); end
    // push and pop on the same edge while full
    pc = 15'o00406; state = 4'h0; rd = 1'b1;
    tick();
    rd = 1'b0; state = 4'h1;
    tick();
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL ovf_pp_count got %0d exp 4", count); end
    checks++; if (dropped !== 8'd2) begin errors++; $display("FAIL ovf_pp_dropped got %0d exp 2", dropped); end
    exp_pc[0] = 15'o00401; exp_pc[1] = 15'o00402; exp_pc[2] = 15'o00403; exp_pc[3] = 15'o00406;
    for (int i = 0; i < 4; i++) begin
      checks++; if (rd_data[14:0] !== exp_pc[i]) begin errors++; $display("FAIL ovf_drain%0d got %o exp %o", i, rd_data[14:0], exp_pc[i]); end
      pop();
    end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL ovf_drained got %0d exp 0", count); end
  endtask

  task automatic test_halt();
    sample_every = 16'd0; max_cycles = 32'd0;
    do_reset();
    do_fetch(15'o00205, 12'o7300, 12'd0, 1'b0, 1'b0);
    do_fetch(15'o00206, 12'o1234, 12'o0055, 1'b1, 1'b0);
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_pre got %0h exp 0", halted); end
    pc = 15'o00207; mb = 12'o7402; ac = 12'o0055; l = 1'b1; ion = 1'b1;
    state = 4'hC;
    tick();
    pc = 15'o00210;
    for (int i = 0; i < 4; i++) tick();
    state = 4'h1;
    tick();
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_flag got %0h exp 1", halted); end
    checks++; if (halt_pc !== 15'o00207) begin errors++; $display("FAIL halt_pc got %o exp 207", halt_pc); end
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL halt_count got %0d exp 3", count); end
    checks++; if (cycle_count !== 32'd2) begin errors++; $display("FAIL halt_cycle got %0d exp 2", cycle_count); end
    pop(); pop();
    checks++; if (rd_data !== {1'b1, 1'b1, 1'b1, 12'o0055, 12'o7402, 15'o00207}) begin errors++; $display("FAIL halt_rec got %h exp %h", rd_data, {1'b1, 1'b1, 1'b1, 12'o0055, 12'o7402, 15'o00207}); end
    pop();
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL halt_single got %0h exp 0", rd_valid); end
  endtask

  task automatic test_reset_mid();
    sample_every = 16'd0; max_cycles = 32'd0;
    do_reset();
    for (int i = 0; i < 5; i++) do_fetch(15'o00500 + 15'(i), 12'd0, 12'd0, 1'b0, 1'b0);
    pop();
    checks++; if ({count, overflow} !== {3'd3, 1'b1}) begin errors++; $display("FAIL mid_setup got %0d/%0h exp 3/1", count, overflow); end
    do_reset();
    checks++; if ({rd_valid, count} !== 4'b0000) begin errors++; $display("FAIL mid_fifo got %0h/%0d exp 0/0", rd_valid, count); end
    checks++; if ({overflow, dropped, cycle_count} !== 41'd0) begin errors++; $display("FAIL mid_ctrs got %0h/%0d/%0d exp 0/0/0", overflow, dropped, cycle_count); end
    do_fetch(15'o00600, 12'd0, 12'd0, 1'b0, 1'b0);
    checks++; if (cycle_count !== 32'd1) begin errors++; $display("FAIL mid_cycle got %0d exp 1", cycle_count); end
    checks++; if (rd_data[14:0] !== 15'o00600) begin errors++; $display("FAIL mid_head got %o exp 600", rd_data[14:0]); end
  endtask

  task automatic test_enable();
    sample_every = 16'd0; max_cycles = 32'd0;
    do_reset();
    enable = 1'b0;
    do_fetch(15'o00700, 12'd0, 12'd0, 1'b0, 1'b0);
    state = 4'hC;
    tick();
    state = 4'h1;
    tick();
    checks++; if ({count, cycle_count} !== 35'd0) begin errors++; $display("FAIL en_off got %0d/%0d exp 0/0", count, cycle_count); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL en_halt got %0h exp 0", halted); end
    enable = 1'b1;
  endtask

  initial begin
    reset = 1'b0; enable = 1'b1; state = 4'h1; pc = '0; mb = '0; ac = '0;
    l = 1'b0; ion = 1'b0; sample_every = '0; max_cycles = '0; rd = 1'b0;
    tick();
    test_reset();
    test_basic();
    test_decimation();
    test_limit();
    test_overflow();
    test_halt();
    test_reset_mid();
    test_enable();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
